// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use stall, mispredict flush,
// E-operand forwarding, ebreak drain/halt sequencing and performance counters.
module pipe_hazard_ctrl #(
    parameter int         CNT_W      = 32,
    parameter logic [1:0] WB_SRC_MEM = 2'd1
) (
    input  logic             _clk,
    input  logic             _rst_n,
    input  logic             _id_valid,
    input  logic [4:0]       _id_rs1,
    input  logic [4:0]       _id_rs2,
    input  logic             _ex_valid,
    input  logic [4:0]       _ex_rs1,
    input  logic [4:0]       _ex_rs2,
    input  logic [4:0]       _ex_rd,
    input  logic             _ex_wb_we,
    input  logic [1:0]       _ex_wb_src,
    input  logic             _ex_is_bcond,
    input  logic             _ex_pred_taken,
    input  logic             _ex_act_taken,
    input  logic             _ex_ebreak,
    input  logic             _mem_valid,
    input  logic             _mem_wb_we,
    input  logic [4:0]       _mem_rd,
    input  logic [1:0]       _mem_wb_src,
    input  logic             _wb_valid,
    input  logic             _wb_wb_we,
    input  logic             _wb_ebreak,
    input  logic [4:0]       _wb_rd,
    input  logic             _resume,
    output logic             lw_block_,
    output logic             flush_fd_,
    output logic             flush_de_,
    output logic             redirect_,
    output logic [1:0]       fwd_rs1_sel_,
    output logic [1:0]       fwd_rs2_sel_,
    output logic             halted_,
    output logic [CNT_W-1:0] cnt_cycle_,
    output logic [CNT_W-1:0] cnt_retired_,
    output logic [CNT_W-1:0] cnt_stall_,
    output logic [CNT_W-1:0] cnt_flush_
);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    state_t state, state_nxt;
    logic   lu, mp, m_fwd, w_fwd;

    assign lu = _ex_valid & _ex_wb_we & (_ex_wb_src == WB_SRC_MEM) & (_ex_rd != 5'd0) &
                _id_valid & ((_id_rs1 == _ex_rd) | (_id_rs2 == _ex_rd));
    assign mp = _ex_valid & _ex_is_bcond & (_ex_pred_taken != _ex_act_taken);

    // A load in M has no data yet, so only non-load results are forwardable from M.
    assign m_fwd = _mem_valid & _mem_wb_we & (_mem_wb_src != WB_SRC_MEM);
    assign w_fwd = _wb_valid & _wb_wb_we;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic mf,
                                           input logic [4:0] mrd, input logic wf,
                                           input logic [4:0] wrd);
        if (src == 5'd0)             return 2'd0;
        else if (mf && mrd == src)   return 2'd1;
        else if (wf && wrd == src)   return 2'd2;
        else                         return 2'd0;
    endfunction

    assign fwd_rs1_sel_ = fwd_sel(_ex_rs1, m_fwd, _mem_rd, w_fwd, _wb_rd);
    assign fwd_rs2_sel_ = fwd_sel(_ex_rs2, m_fwd, _mem_rd, w_fwd, _wb_rd);
    assign redirect_    = mp;
    assign halted_      = (state == HALTED);

    always_ff @(posedge _clk or negedge _rst_n) begin
        if (!_rst_n) state <= RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lw_block_ = 1'b0;
        flush_fd_ = mp;
        flush_de_ = mp;
        case (state)
            RUN: begin
                lw_block_ = lu & ~mp;
                flush_de_ = lu | mp;
                if (_ex_valid & _ex_ebreak & ~mp) state_nxt = DRAIN;
            end
            DRAIN: begin
                lw_block_ = 1'b1;
                flush_fd_ = 1'b1;
                flush_de_ = 1'b1;
                if (_wb_valid & _wb_ebreak) state_nxt = HALTED;
            end
            HALTED: begin
                lw_block_ = 1'b1;
                flush_de_ = 1'b1;
                if (_resume) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge _clk or negedge _rst_n) begin
        if (!_rst_n) begin
            cnt_cycle_   <= '0;
            cnt_retired_ <= '0;
            cnt_stall_   <= '0;
            cnt_flush_   <= '0;
        end else begin
            if (state != HALTED)              cnt_cycle_   <= cnt_cycle_ + 1'b1;
            if (_wb_valid && state != HALTED) cnt_retired_ <= cnt_retired_ + 1'b1;
            if (state == RUN && lu && !mp)    cnt_stall_   <= cnt_stall_ + 1'b1;
            if (mp)                           cnt_flush_   <= cnt_flush_ + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized cycles,
// expectations from a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int CMOD  = 1 << CNT_W;

    typedef struct {
        logic id_valid; logic [4:0] id_rs1, id_rs2;
        logic ex_valid; logic [4:0] ex_rs1, ex_rs2, ex_rd; logic ex_wb_we; logic [1:0] ex_wb_src;
        logic ex_is_bcond, pred, act, ex_ebreak;
        logic mem_valid, mem_wb_we; logic [4:0] mem_rd; logic [1:0] mem_wb_src;
        logic wb_valid, wb_wb_we, wb_ebreak; logic [4:0] wb_rd;
        logic resume;
    } stim_t;

    typedef struct {
        int lw_block, flush_fd, flush_de, redirect, fwd1, fwd2, halted;
        int cyc, ret, stall, flush;
    } exp_t;

    logic clk = 0, rst_n = 0;
    stim_t s;
    logic lw_block, flush_fd, flush_de, redirect, halted;
    logic [1:0] fwd1, fwd2;
    logic [CNT_W-1:0] cnt_cycle, cnt_retired, cnt_stall, cnt_flush;

    exp_t q[$];
    int checks = 0, errors = 0;

    // Model state: 0 running, 1 draining after ebreak, 2 stopped
    int mode = 0, m_cyc = 0, m_ret = 0, m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .WB_SRC_MEM(2'd1)) dut (
        ._clk(clk), ._rst_n(rst_n),
        ._id_valid(s.id_valid), ._id_rs1(s.id_rs1), ._id_rs2(s.id_rs2),
        ._ex_valid(s.ex_valid), ._ex_rs1(s.ex_rs1), ._ex_rs2(s.ex_rs2), ._ex_rd(s.ex_rd),
        ._ex_wb_we(s.ex_wb_we), ._ex_wb_src(s.ex_wb_src), ._ex_is_bcond(s.ex_is_bcond),
        ._ex_pred_taken(s.pred), ._ex_act_taken(s.act), ._ex_ebreak(s.ex_ebreak),
        ._mem_valid(s.mem_valid), ._mem_wb_we(s.mem_wb_we), ._mem_rd(s.mem_rd),
        ._mem_wb_src(s.mem_wb_src),
        ._wb_valid(s.wb_valid), ._wb_wb_we(s.wb_wb_we), ._wb_ebreak(s.wb_ebreak), ._wb_rd(s.wb_rd),
        ._resume(s.resume),
        .lw_block_(lw_block), .flush_fd_(flush_fd), .flush_de_(flush_de), .redirect_(redirect),
        .fwd_rs1_sel_(fwd1), .fwd_rs2_sel_(fwd2), .halted_(halted),
        .cnt_cycle_(cnt_cycle), .cnt_retired_(cnt_retired), .cnt_stall_(cnt_stall),
        .cnt_flush_(cnt_flush)
    );

    function automatic stim_t idle();
        stim_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic stim_t rnd();
        stim_t t;
        t.id_valid = 1'($urandom_range(0, 3) != 0);
        t.id_rs1 = 5'($urandom_range(0, 3)); t.id_rs2 = 5'($urandom_range(0, 3));
        t.ex_valid = 1'($urandom_range(0, 3) != 0);
        t.ex_rs1 = 5'($urandom_range(0, 3)); t.ex_rs2 = 5'($urandom_range(0, 3));
        t.ex_rd = 5'($urandom_range(0, 3)); t.ex_wb_we = 1'($urandom);
        t.ex_wb_src = 2'($urandom_range(0, 2));
        t.ex_is_bcond = 1'($urandom_range(0, 2) == 0);
        t.pred = 1'($urandom); t.act = 1'($urandom);
        t.ex_ebreak = 1'($urandom_range(0, 15) == 0);
        t.mem_valid = 1'($urandom); t.mem_wb_we = 1'($urandom);
        t.mem_rd = 5'($urandom_range(0, 3)); t.mem_wb_src = 2'($urandom_range(0, 2));
        t.wb_valid = 1'($urandom); t.wb_wb_we = 1'($urandom);
        t.wb_rd = 5'($urandom_range(0, 3));
        t.wb_ebreak = 1'($urandom_range(0, 5) == 0);
        t.resume = 1'($urandom_range(0, 3) == 0);
        return t;
    endfunction

    function automatic bit load_use(stim_t t);
        if (!(t.ex_valid && t.ex_wb_we && t.ex_wb_src == 2'd1 && t.ex_rd != 0 && t.id_valid))
            return 0;
        return t.id_rs1 == t.ex_rd || t.id_rs2 == t.ex_rd;
    endfunction

    function automatic bit mispredict(stim_t t);
        return t.ex_valid && t.ex_is_bcond && t.pred != t.act;
    endfunction

    // Where an E operand comes from: youngest producer with data available wins.
    function automatic int operand_src(logic [4:0] r, stim_t t);
        if (r == 0) return 0;
        if (t.mem_valid && t.mem_wb_we && t.mem_rd == r && t.mem_wb_src != 2'd1) return 1;
        if (t.wb_valid && t.wb_wb_we && t.wb_rd == r) return 2;
        return 0;
    endfunction

    function automatic exp_t predict(stim_t t, bit in_reset);
        exp_t e;
        bit lu, mp;
        lu = load_use(t);
        mp = mispredict(t);
        e.redirect = int'(mp);
        e.flush_fd = int'(mp || mode == 1);
        e.flush_de = int'(lu || mp || mode != 0);
        e.lw_block = int'(mode != 0 || (lu && !mp));
        e.halted   = int'(mode == 2);
        e.fwd1 = operand_src(t.ex_rs1, t);
        e.fwd2 = operand_src(t.ex_rs2, t);
        e.cyc = m_cyc; e.ret = m_ret; e.stall = m_stall; e.flush = m_flush;
        if (in_reset) e = '{default: 0};
        return e;
    endfunction

    task automatic advance_model(stim_t t);
        bit lu, mp;
        if (!rst_n) begin
            mode = 0; m_cyc = 0; m_ret = 0; m_stall = 0; m_flush = 0;
            return;
        end
        lu = load_use(t);
        mp = mispredict(t);
        if (mode != 2) m_cyc = (m_cyc + 1) % CMOD;
        if (mode != 2 && t.wb_valid) m_ret = (m_ret + 1) % CMOD;
        if (mode == 0 && lu && !mp) m_stall = (m_stall + 1) % CMOD;
        if (mp) m_flush = (m_flush + 1) % CMOD;
        if (mode == 0 && t.ex_valid && t.ex_ebreak && !mp) mode = 1;
        else if (mode == 1 && t.wb_valid && t.wb_ebreak) mode = 2;
        else if (mode == 2 && t.resume) mode = 0;
    endtask

    task automatic cycle(stim_t t);
        @(negedge clk);
        rst_n = 1;
        s = t;
        #1;
        q.push_back(predict(t, 0));
        @(posedge clk);
        advance_model(t);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n = 0;
        s = idle();
        #1;
        advance_model(s);
        q.push_back(predict(s, 1));
        @(posedge clk);
        advance_model(s);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are stable 2 time units after the negedge that applied the inputs.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("lw_block", int'(lw_block), e.lw_block);
            chk("flush_fd", int'(flush_fd), e.flush_fd);
            chk("flush_de", int'(flush_de), e.flush_de);
            chk("redirect", int'(redirect), e.redirect);
            chk("fwd_rs1_sel", int'(fwd1), e.fwd1);
            chk("fwd_rs2_sel", int'(fwd2), e.fwd2);
            chk("halted", int'(halted), e.halted);
            chk("cnt_cycle", int'(cnt_cycle), e.cyc);
            chk("cnt_retired", int'(cnt_retired), e.ret);
            chk("cnt_stall", int'(cnt_stall), e.stall);
            chk("cnt_flush", int'(cnt_flush), e.flush);
        end
    end

    initial begin
        stim_t t;
        s = idle();
        reset_cycle();
        // Load-use: lw x5 in E, consumer of x5 in D; then load in W feeds rs1
        t = idle(); t.ex_valid = 1; t.ex_wb_we = 1; t.ex_wb_src = 1; t.ex_rd = 5;
        t.id_valid = 1; t.id_rs1 = 5; cycle(t);
        t = idle(); t.mem_valid = 1; t.mem_wb_we = 1; t.mem_wb_src = 1; t.mem_rd = 5; cycle(t);
        t = idle(); t.ex_valid = 1; t.ex_rs1 = 5; t.wb_valid = 1; t.wb_wb_we = 1; t.wb_rd = 5;
        t.mem_valid = 1; t.mem_wb_we = 1; t.mem_wb_src = 1; t.mem_rd = 5; cycle(t);
        // M beats W; x0 never forwards
        t = idle(); t.ex_valid = 1; t.ex_rs2 = 7; t.mem_valid = 1; t.mem_wb_we = 1; t.mem_rd = 7;
        t.wb_valid = 1; t.wb_wb_we = 1; t.wb_rd = 7; cycle(t);
        t.ex_rs2 = 0; t.mem_rd = 0; t.wb_rd = 0; cycle(t);
        // Mispredict with load-use: flush wins, no stall
        t = idle(); t.ex_valid = 1; t.ex_is_bcond = 1; t.act = 1; t.ex_wb_we = 1; t.ex_wb_src = 1;
        t.ex_rd = 3; t.id_valid = 1; t.id_rs2 = 3; cycle(t);
        cycle(idle());
        // Ebreak drain, halt, frozen counters, resume
        t = idle(); t.ex_valid = 1; t.ex_ebreak = 1; cycle(t);
        t = idle(); t.resume = 1; cycle(t);
        cycle(idle());
        t = idle(); t.wb_valid = 1; t.wb_ebreak = 1; cycle(t);
        repeat (3) cycle(idle());
        t = idle(); t.wb_valid = 1; cycle(t);
        t = idle(); t.resume = 1; cycle(t);
        // 16+ plain cycles to wrap the cycle counter
        repeat (18) cycle(idle());
        // Reset while draining
        t = idle(); t.ex_valid = 1; t.ex_ebreak = 1; cycle(t);
        t = idle(); t.wb_valid = 1; cycle(t);
        reset_cycle();
        cycle(idle());
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) reset_cycle();
            else cycle(rnd());
        end
        repeat (3) @(negedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage core (F, D, E, M, W).
- Watches register IDs, valid bits and control signals of the instructions in D, E, M and W.
- Drives the decode-register clock mask (load-use stall), bubble/flush controls, branch redirect and execute-operand forwarding selects.
- Runs the ebreak drain/halt state machine and keeps saturating-free performance counters.

Parameters:
- CNT_W, 32, width of each performance counter (wraps modulo 2^CNT_W).
- WB_SRC_MEM, 2'd1, `sig_wb_src` encoding that marks a load (write-back from memory).

Ports:
- _clk  in  1  core clock
- _rst_n  in  1  asynchronous active-low reset
- _id_valid  in  1  instruction in D is valid
- _id_rs1, _id_rs2  in  5 each  sources of instruction in D
- _ex_valid  in  1  instruction in E is valid
- _ex_rs1, _ex_rs2  in  5 each  sources of instruction in E
- _ex_rd  in  5  destination of instruction in E
- _ex_wb_we  in  1  instruction in E writes a register
- _ex_wb_src  in  2  write-back source of instruction in E
- _ex_is_bcond  in  1  instruction in E is a conditional branch
- _ex_pred_taken  in  1  predicted direction
- _ex_act_taken  in  1  resolved direction
- _ex_ebreak  in  1  instruction in E is ebreak
- _mem_valid, _mem_wb_we  in  1 each  M-stage valid and register write
- _mem_rd  in  5  M-stage destination
- _mem_wb_src  in  2  M-stage write-back source
- _wb_valid, _wb_wb_we, _wb_ebreak  in  1 each  W-stage valid, register write, ebreak
- _wb_rd  in  5  W-stage destination
- _resume  in  1  leave HALTED
- lw_block_  out  1  hold F and D registers (feeds the D-stage clock mask)
- flush_fd_  out  1  force D-register valid to 0 next edge
- flush_de_  out  1  force E-register valid to 0 next edge (bubble)
- redirect_  out  1  fetch takes the corrected target this cycle
- fwd_rs1_sel_, fwd_rs2_sel_  out  2 each  operand source: 0 = regfile, 1 = M alu_res, 2 = W result
- halted_  out  1  core halted
- cnt_cycle_, cnt_retired_, cnt_stall_, cnt_flush_  out  CNT_W each  performance counters

Behaviour:
- **Reset** (async, _rst_n=0):
  - state = RUN, halted_ = 0, all counters = 0.
  - All combinational outputs evaluate to 0 because every valid is 0 after reset.
- **States:** RUN, DRAIN, HALTED (2-bit register).
- **Load-use** (combinational):
  - Condition: `lu = _ex_valid & _ex_wb_we & _ex_wb_src==WB_SRC_MEM & _ex_rd!=0 & _id_valid & (_id_rs1==_ex_rd | _id_rs2==_ex_rd)`.
  - When lu=1: lw_block_=1 and flush_de_=1 for exactly 1 cycle.
  - Next cycle the load is in M and E holds a bubble, so lu deasserts naturally.
- **Mispredict** (combinational):
  - Condition: `mp = _ex_valid & _ex_is_bcond & (_ex_pred_taken != _ex_act_taken)`.
  - When mp=1: redirect_=1, flush_fd_=1, flush_de_=1.
  - mp forces lw_block_=0 (mispredict has priority over load-use; the stalled consumer is on the wrong path).
- **Forwarding**, evaluated per source s in {rs1, rs2}:
  - s == 0: sel = 0.
  - Else sel = 1 if `_mem_valid & _mem_wb_we & _mem_rd==s & _mem_wb_src!=WB_SRC_MEM`.
  - Else sel = 2 if `_wb_valid & _wb_wb_we & _wb_rd==s`.
  - Else sel = 0.
  - M has priority over W.
  - Selects are driven regardless of _ex_valid.
- **FSM:**
  - RUN → DRAIN when `_ex_valid & _ex_ebreak & !mp`.
  - DRAIN:
    - lw_block_=1, flush_fd_=1, flush_de_=1 every cycle (younger work is discarded, F/D frozen).
    - → HALTED when `_wb_valid & _wb_ebreak`.
  - HALTED:
    - halted_=1, lw_block_=1, flush_de_=1.
    - → RUN on `_resume=1` (sampled at the edge).
    - _resume is ignored in RUN and DRAIN.
  - The ebreak in E enters M on the same edge as the RUN → DRAIN transition, i.e. it is not flushed.
- **Counters** (registered, wrap, never saturate):
  - cnt_cycle_ +1 every edge while state != HALTED.
  - cnt_retired_ +1 when `_wb_valid & state != HALTED`.
  - cnt_stall_ +1 when lu drives lw_block_ in RUN.
  - cnt_flush_ +1 when mp=1.
- **Reset mid-DRAIN:** returns to RUN; counters are cleared.

Test Plan:
1. Load-use: lw x5 in E (wb_src=1, rd=5), add reads x5 in D → lw_block_=1 and flush_de_=1 for 1 cycle; two cycles later fwd_rs1_sel_=2 from W; cnt_stall_=1.
2. ALU back-to-back: rd=7 in M, E reads rs2=7, W also has rd=7 → fwd_rs2_sel_=1 (M wins). Same case with rd=0 → sel=0.
3. Mispredict coinciding with load-use: pred=0, act=1, and lu conditions true → redirect_=1, flush_fd_=1, flush_de_=1, lw_block_=0; cnt_flush_=1, cnt_stall_ unchanged.
4. Ebreak: ebreak valid in E → DRAIN with lw_block_=1; two cycles later _wb_ebreak=1 → halted_=1 next cycle; cnt_cycle_ frozen; _resume pulse → RUN, halted_=0.
5. Reset asserted while in DRAIN with counters nonzero → immediately halted_=0, all counters 0, state RUN, all outputs 0.
6. Counter wrap: CNT_W=4, run 16 unstalled cycles → cnt_cycle_ wraps from 15 to 0.
